mandel_view_regs: RTL and testbench
===================================

Name: mandel_view_regs

Overview:
- AXI4-Lite slave register file that lets the ARM PS set the Mandelbrot viewport and control frame generation.
- Sits directly upstream of pixel_scheduler and replaces the hardwired viewport constants and auto-start logic in the top level.
- Software writes shadow registers. The block commits them atomically to active outputs on each frame start, so a frame never mixes old and new viewport values.

Parameters:
- WIDTH, 32, fixed-point coordinate width (Q4.28)
- ITER_W, 16, iteration-count width
- ADDR_W, 6, AXI address width (byte addressed)
- VERSION, 32'h4D42_0001, read-only ID value

Ports:
- clk  in  1  compute clock
- rst_n  in  1  asynchronous active-low reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_W  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- frame_busy  in  1  scheduler busy
- frame_done  in  1  scheduler frame-complete pulse
- frame_start  out  1  one-cycle start pulse to scheduler
- c_re_start  out  WIDTH  active real start (signed)
- c_im_start  out  WIDTH  active imaginary start (signed)
- c_re_step  out  WIDTH  active real step
- c_im_step  out  WIDTH  active imaginary step
- max_iter  out  ITER_W  active iteration limit

Behaviour:
- Register map:
  - 0x00 CTRL, RW. bit0 AUTO_RUN (reset 1). bit1 START is write-1 to set a pending request and reads back as pending.
  - 0x04 STATUS, bit0 BUSY (RO, mirrors frame_busy). bit1 DONE (sticky, write-1 to clear).
  - 0x08 CRE_START, 0x0C CIM_START, 0x10 CRE_STEP, 0x14 CIM_STEP, 0x18 MAX_ITER[ITER_W-1:0]: all RW shadows.
  - 0x1C FRAME_CNT, RO, 32-bit, wraps at 2^32.
  - 0x20 VERSION, RO.
  - Any other offset: OKAY is not returned. Writes are ignored and give SLVERR (2'b10); reads return 0 with SLVERR.
- Shadow reset values, also loaded into active outputs at reset:
  - CRE_START E000_0000, CIM_START F319_999A.
  - CRE_STEP 0026_6666, CIM_STEP 0026_6666.
  - MAX_ITER 256.
- Output reset values: frame_start 0, all AXI ready/valid 0, bresp/rresp 0, rdata 0.
- Write channel:
  - AW and W are accepted independently. Each ready is high while its buffer is empty and bvalid is low.
  - When both are held, the register is updated honouring wstrb per byte and bvalid asserts the next cycle.
  - bvalid is held until bready. Only one write is outstanding at a time.
- Read channel:
  - arready is high when rvalid is low.
  - rvalid with rdata asserts one cycle after the AR handshake and is held until rready.
- Start arbiter:
  - start_ok = !frame_busy && !frame_start && !start_gap, where start_gap is a 1-cycle flag set after a pulse so busy can rise.
  - Fire frame_start for one cycle when start_ok and either START is pending, or AUTO_RUN=1 and (the first cycle after reset or frame_done was seen since the last start).
  - In the same cycle as the pulse, all shadows are copied to the active outputs and the pending START is cleared.
- frame_done pulse: sets DONE, increments FRAME_CNT, and arms an auto-run restart.
- Simultaneous events:
  - A START write in the firing cycle stays pending and is served by the next frame.
  - A shadow write in the commit cycle lands in the shadow and applies from the next frame.
  - A DONE write-1-clear coinciding with a frame_done pulse leaves DONE set.
- Reset mid-transaction aborts the AXI handshakes and returns all state to reset values.

Decomposition:
- Shared package mandel_pkg holds:
  - register offsets;
  - default viewport constants (shared with the top level);
  - the SLVERR/OKAY codes.
- One natural sub-module, axil_slave_if: the AW/W/B/AR/R handshake engine. It presents a simple wr_en/wr_addr/wr_data/wr_strb plus rd_en/rd_addr/rd_data interface and takes an error flag.

Test Plan:
- Reset, no bus activity:
  - frame_start pulses once within 3 cycles of reset release.
  - Outputs show c_re_start=E000_0000, c_im_start=F319_999A, c_re_step=0026_6666, c_im_step=0026_6666, max_iter=256.
  - Read 0x20 returns 4D42_0001, OKAY.
- Shadow isolation and commit:
  - Write 0x10 = 0001_0000 while frame_busy=1 → c_re_step is unchanged.
  - After a frame_done pulse and busy falling → c_re_step becomes 0001_0000 in the same cycle as frame_start.
- Handshake ordering:
  - W presented 5 cycles before AW with wstrb=4'b0011 on 0x18 = FFFF_0400.
  - Response: single bvalid held until bready, max_iter shadow reads 0x0400.
- Manual control:
  - Clear AUTO_RUN (CTRL=0), drive 3 frame_done pulses → no frame_start. FRAME_CNT reads 3, STATUS.DONE=1.
  - Write STATUS=2 → DONE=0.
  - Write CTRL=2 → exactly one frame_start.
- Bad address:
  - Write to 0x3C → bresp=2'b10, no register changes.
  - Read 0x24 → rdata=0, rresp=2'b10.
- Back-to-back reads with rready held low 4 cycles: rdata is stable throughout and arready stays 0 until the R handshake completes.

Source files
------------

// File: rtl/mandel_pkg.sv
// mandel_pkg: register offsets, default viewport, AXI response codes and byte-strobe merge shared by the viewport register block
package mandel_pkg;
  localparam logic [31:0] REG_CTRL      = 32'h00;
  localparam logic [31:0] REG_STATUS    = 32'h04;
  localparam logic [31:0] REG_CRE_START = 32'h08;
  localparam logic [31:0] REG_CIM_START = 32'h0C;
  localparam logic [31:0] REG_CRE_STEP  = 32'h10;
  localparam logic [31:0] REG_CIM_STEP  = 32'h14;
  localparam logic [31:0] REG_MAX_ITER  = 32'h18;
  localparam logic [31:0] REG_FRAME_CNT = 32'h1C;
  localparam logic [31:0] REG_VERSION   = 32'h20;
  localparam logic [31:0] DEF_CRE_START = 32'hE000_0000;
  localparam logic [31:0] DEF_CIM_START = 32'hF319_999A;
  localparam logic [31:0] DEF_CRE_STEP  = 32'h0026_6666;
  localparam logic [31:0] DEF_CIM_STEP  = 32'h0026_6666;
  localparam logic [31:0] DEF_MAX_ITER  = 32'd256;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  function automatic logic reg_hit(input logic [31:0] a);
    return a[1:0] == 2'b00 && a <= REG_VERSION;
  endfunction
endpackage

// File: rtl/axil_slave_if.sv
// axil_slave_if: AXI4-Lite slave handshake engine turning AW/W/B/AR/R into single-cycle wr_en/rd_en register strobes
//   s_aw*/s_w*/s_b*/s_ar*/s_r* : AXI4-Lite slave channels (readies/valids registered, low in reset)
//   wr_en/wr_addr/wr_data/wr_strb : one-cycle write strobe once both AW and W are buffered; wr_err selects SLVERR
//   rd_en/rd_addr/rd_data : read strobe on the AR handshake; rd_data/rd_err captured into R the same edge
module axil_slave_if import mandel_pkg::*; #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);
  logic aw_full, w_full, aw_full_n, w_full_n, bvalid_n, rvalid_n;
  assign wr_en     = aw_full && w_full;
  assign rd_en     = s_arvalid && s_arready;
  assign rd_addr   = s_araddr;
  assign aw_full_n = !wr_en && (aw_full || (s_awvalid && s_awready));
  assign w_full_n  = !wr_en && (w_full || (s_wvalid && s_wready));
  assign bvalid_n  = wr_en || (s_bvalid && !s_bready);
  assign rvalid_n  = rd_en || (s_rvalid && !s_rready);
  // Readies are registered from next-state so a just-filled buffer closes its channel without a combinational path.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strb   <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      aw_full   <= aw_full_n;
      w_full    <= w_full_n;
      if (s_awvalid && s_awready) wr_addr <= s_awaddr;
      if (s_wvalid && s_wready) begin
        wr_data <= s_wdata;
        wr_strb <= s_wstrb;
      end
      s_awready <= !aw_full_n && !bvalid_n;
      s_wready  <= !w_full_n && !bvalid_n;
      s_bvalid  <= bvalid_n;
      if (wr_en) s_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      s_arready <= !rvalid_n;
      s_rvalid  <= rvalid_n;
      if (rd_en) begin
        s_rdata <= rd_err ? '0 : rd_data;
        s_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
endmodule

// File: rtl/mandel_view_regs.sv
// mandel_view_regs: AXI4-Lite viewport/control registers with shadow-to-active commit on every frame_start
//   clk/rst_n : clock, asynchronous active-low reset
//   s_*       : AXI4-Lite slave port (CTRL, STATUS, viewport shadows, FRAME_CNT, VERSION)
//   frame_busy/frame_done : scheduler status inputs
//   frame_start : one-cycle start pulse; c_*/max_iter : active viewport, updated only with frame_start
module mandel_view_regs import mandel_pkg::*; #(
  parameter int          WIDTH   = 32,
  parameter int          ITER_W  = 16,
  parameter int          ADDR_W  = 6,
  parameter logic [31:0] VERSION = 32'h4D42_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic              frame_busy,
  input  logic              frame_done,
  output logic              frame_start,
  output logic [WIDTH-1:0]  c_re_start,
  output logic [WIDTH-1:0]  c_im_start,
  output logic [WIDTH-1:0]  c_re_step,
  output logic [WIDTH-1:0]  c_im_step,
  output logic [ITER_W-1:0] max_iter
);
  logic              wr_en, rd_en, wr_err, rd_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, rd_data, wa, ra;
  logic [3:0]        wr_strb;
  logic              auto_run, start_pend, done_flag, start_gap, auto_arm, start_ok, fire;
  logic              w_ctrl, w_status, start_set, done_clr;
  logic [WIDTH-1:0]  sh_re_start, sh_im_start, sh_re_step, sh_im_step;
  logic [ITER_W-1:0] sh_max_iter;
  logic [31:0]       frame_cnt;

  axil_slave_if #(.ADDR_W(ADDR_W)) u_if (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
  );

  assign wa        = 32'(wr_addr);
  assign ra        = 32'(rd_addr);
  assign wr_err    = !reg_hit(wa);
  assign rd_err    = !reg_hit(ra);
  assign w_ctrl    = wr_en && wa == REG_CTRL && wr_strb[0];
  assign w_status  = wr_en && wa == REG_STATUS && wr_strb[0];
  assign start_set = w_ctrl && wr_data[1];
  assign done_clr  = w_status && wr_data[1];
  // start_gap holds off one extra cycle after a pulse so frame_busy has time to rise.
  assign start_ok  = !frame_busy && !frame_start && !start_gap;
  assign fire      = start_ok && (start_pend || (auto_run && auto_arm));

  always_comb
    rd_data = !rd_en                ? '0 :
              ra == REG_CTRL        ? {30'd0, start_pend, auto_run} :
              ra == REG_STATUS      ? {30'd0, done_flag, frame_busy} :
              ra == REG_CRE_START   ? 32'(sh_re_start) :
              ra == REG_CIM_START   ? 32'(sh_im_start) :
              ra == REG_CRE_STEP    ? 32'(sh_re_step) :
              ra == REG_CIM_STEP    ? 32'(sh_im_step) :
              ra == REG_MAX_ITER    ? 32'(sh_max_iter) :
              ra == REG_FRAME_CNT   ? frame_cnt :
              ra == REG_VERSION     ? VERSION : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      auto_run    <= 1'b1;
      start_pend  <= 1'b0;
      done_flag   <= 1'b0;
      start_gap   <= 1'b0;
      auto_arm    <= 1'b1;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      sh_re_start <= WIDTH'(DEF_CRE_START);
      sh_im_start <= WIDTH'(DEF_CIM_START);
      sh_re_step  <= WIDTH'(DEF_CRE_STEP);
      sh_im_step  <= WIDTH'(DEF_CIM_STEP);
      sh_max_iter <= ITER_W'(DEF_MAX_ITER);
      c_re_start  <= WIDTH'(DEF_CRE_START);
      c_im_start  <= WIDTH'(DEF_CIM_START);
      c_re_step   <= WIDTH'(DEF_CRE_STEP);
      c_im_step   <= WIDTH'(DEF_CIM_STEP);
      max_iter    <= ITER_W'(DEF_MAX_ITER);
    end else begin
      frame_start <= fire;
      start_gap   <= frame_start;
      auto_arm    <= frame_done || (auto_arm && !fire);
      start_pend  <= start_set || (start_pend && !fire);
      done_flag   <= frame_done || (done_flag && !done_clr);
      frame_cnt   <= frame_cnt + 32'(frame_done);
      if (w_ctrl) auto_run <= wr_data[0];
      if (wr_en && wa == REG_CRE_START) sh_re_start <= WIDTH'(apply_strb(32'(sh_re_start), wr_data, wr_strb));
      if (wr_en && wa == REG_CIM_START) sh_im_start <= WIDTH'(apply_strb(32'(sh_im_start), wr_data, wr_strb));
      if (wr_en && wa == REG_CRE_STEP) sh_re_step <= WIDTH'(apply_strb(32'(sh_re_step), wr_data, wr_strb));
      if (wr_en && wa == REG_CIM_STEP) sh_im_step <= WIDTH'(apply_strb(32'(sh_im_step), wr_data, wr_strb));
      if (wr_en && wa == REG_MAX_ITER) sh_max_iter <= ITER_W'(apply_strb(32'(sh_max_iter), wr_data, wr_strb));
      if (fire) begin
        c_re_start <= sh_re_start;
        c_im_start <= sh_im_start;
        c_re_step  <= sh_re_step;
        c_im_step  <= sh_im_step;
        max_iter   <= sh_max_iter;
      end
    end
endmodule

// File: tb/tb_mandel_view_regs.sv
// tb_mandel_view_regs: self-checking bench for mandel_view_regs with an AXI response scoreboard and a register vector table
module tb_mandel_view_regs;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [5:0]  s_awaddr = '0, s_araddr = '0;
  logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        frame_busy = 0, frame_done = 0, frame_start;
  logic [31:0] c_re_start, c_im_start, c_re_step, c_im_step;
  logic [15:0] max_iter;

  always #5 clk = ~clk;

  mandel_view_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .frame_busy(frame_busy), .frame_done(frame_done), .frame_start(frame_start),
    .c_re_start(c_re_start), .c_im_start(c_im_start), .c_re_step(c_re_step),
    .c_im_step(c_im_step), .max_iter(max_iter)
  );

  localparam logic [1:0] OK = 2'b00, ERR = 2'b10;
  typedef struct {logic [31:0] d; logic [1:0] r;} rexp_t;
  typedef struct {logic [5:0] a; logic [31:0] d; logic [3:0] st; logic [1:0] br; logic [31:0] rd; logic [1:0] rr;} vec_t;
  rexp_t       rq[$];
  logic [1:0]  bq[$];
  vec_t        tbl[9];
  int          tests = 0, fails = 0, fs_cnt = 0, fs0 = 0, cnt_model = 0;
  logic [31:0] prev_step = '0, step_at_fs = '0, step_before_fs = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard / monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    rexp_t e;
    if (frame_start) begin
      fs_cnt++;
      step_at_fs = c_re_step;
      step_before_fs = prev_step;
    end
    prev_step = c_re_step;
    if (s_bvalid && s_bready) begin
      if (bq.size() == 0) timeout("unexpected_b");
      else chk("bresp", 32'(s_bresp), 32'(bq.pop_front()));
    end
    if (s_rvalid && s_rready) begin
      if (rq.size() == 0) timeout("unexpected_r");
      else begin
        e = rq.pop_front();
        chk("rdata", s_rdata, e.d);
        chk("rresp", 32'(s_rresp), 32'(e.r));
      end
    end
  end

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int aw_dly, input int b_dly, input logic [1:0] er);
    bit aw_done = 0, w_done = 0, awh, wh, ok = 0;
    bq.push_back(er);
    s_wdata = d;
    s_wstrb = st;
    s_wvalid = 1;
    for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
      if (i == aw_dly) begin
        s_awaddr = a;
        s_awvalid = 1;
      end
      @(negedge clk);
      awh = s_awvalid && s_awready;
      wh = s_wvalid && s_wready;
      @(posedge clk);
      #1;
      if (awh) begin s_awvalid = 0; aw_done = 1; end
      if (wh) begin s_wvalid = 0; w_done = 1; end
    end
    if (!(aw_done && w_done)) begin
      s_awvalid = 0;
      s_wvalid = 0;
      void'(bq.pop_back());
      timeout("aw_w_handshake");
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_bvalid) begin ok = 1; break; end
    end
    if (!ok) begin
      void'(bq.pop_back());
      timeout("bvalid");
      return;
    end
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bvalid_hold", 32'(s_bvalid), 1);
    end
    @(posedge clk);
    #1;
    s_bready = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    s_bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er, input int r_dly);
    bit ok = 0, hs;
    logic [31:0] first;
    rq.push_back('{ed, er});
    s_araddr = a;
    s_arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hs = s_arready;
      @(posedge clk);
      #1;
      if (hs) begin ok = 1; break; end
    end
    s_arvalid = 0;
    if (!ok) begin
      void'(rq.pop_back());
      timeout("ar_handshake");
      return;
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_rvalid) begin ok = 1; break; end
    end
    if (!ok) begin
      void'(rq.pop_back());
      timeout("rvalid");
      return;
    end
    first = s_rdata;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rdata_stable", s_rdata, first);
      chk("rvalid_hold", 32'(s_rvalid), 1);
      chk("arready_low", 32'(s_arready), 0);
    end
    @(posedge clk);
    #1;
    s_rready = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    s_rready = 0;
  endtask

  task automatic pulse_done();
    frame_done = 1;
    cnt_model++;
    cycles(1);
    frame_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{6'h08, 32'h1234_5678, 4'hF, OK,  32'h1234_5678, OK};
    tbl[1] = '{6'h0C, 32'h8765_4321, 4'hC, OK,  32'h8765_999A, OK};
    tbl[2] = '{6'h14, 32'hAABB_CCDD, 4'h1, OK,  32'h0026_66DD, OK};
    tbl[3] = '{6'h18, 32'h0001_FFFF, 4'hF, OK,  32'h0000_FFFF, OK};
    tbl[4] = '{6'h3C, 32'hDEAD_BEEF, 4'hF, ERR, 32'h0,         ERR};
    tbl[5] = '{6'h24, 32'h1111_1111, 4'hF, ERR, 32'h0,         ERR};
    tbl[6] = '{6'h20, 32'h0,         4'hF, OK,  32'h4D42_0001, OK};
    tbl[7] = '{6'h02, 32'hFFFF_FFFF, 4'hF, ERR, 32'h0,         ERR};
    tbl[8] = '{6'h1C, 32'h0,         4'hF, OK,  32'd4,         OK};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_awready", 32'(s_awready), 0);
    chk("rst_wready", 32'(s_wready), 0);
    chk("rst_arready", 32'(s_arready), 0);
    chk("rst_bvalid", 32'(s_bvalid), 0);
    chk("rst_rvalid", 32'(s_rvalid), 0);
    chk("rst_rdata", s_rdata, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("auto_start_after_reset", 32'(fs_cnt), 1);
    @(posedge clk);
    #1;
    frame_busy = 1;
    cycles(5);
    chk("single_auto_start", 32'(fs_cnt), 1);
    chk("def_re_start", c_re_start, 32'hE000_0000);
    chk("def_im_start", c_im_start, 32'hF319_999A);
    chk("def_re_step", c_re_step, 32'h0026_6666);
    chk("def_im_step", c_im_step, 32'h0026_6666);
    chk("def_max_iter", 32'(max_iter), 256);
    axi_read(6'h20, 32'h4D42_0001, OK, 0);
    axi_read(6'h00, 32'h1, OK, 0);

    axi_write(6'h10, 32'h0001_0000, 4'hF, 0, 0, OK);
    cycles(2);
    chk("shadow_isolated", c_re_step, 32'h0026_6666);
    fs0 = fs_cnt;
    pulse_done();
    frame_busy = 0;
    for (int i = 0; i < 10 && fs_cnt == fs0; i++) cycles(1);
    frame_busy = 1;
    chk("restart_count", 32'(fs_cnt), 32'(fs0 + 1));
    chk("commit_with_start", step_at_fs, 32'h0001_0000);
    chk("old_before_start", step_before_fs, 32'h0026_6666);

    axi_write(6'h18, 32'hFFFF_0400, 4'h3, 5, 3, OK);
    cycles(3);
    chk("single_bvalid", 32'(s_bvalid), 0);
    axi_read(6'h18, 32'h0000_0400, OK, 0);
    chk("max_iter_not_committed", 32'(max_iter), 256);

    axi_write(6'h00, 32'h0, 4'hF, 0, 0, OK);
    frame_busy = 0;
    cycles(2);
    fs0 = fs_cnt;
    repeat (3) begin
      pulse_done();
      cycles(2);
    end
    cycles(5);
    chk("no_auto_start", 32'(fs_cnt), 32'(fs0));
    axi_read(6'h1C, 32'(cnt_model), OK, 0);
    axi_read(6'h04, 32'h2, OK, 0);
    axi_write(6'h04, 32'h2, 4'hF, 0, 0, OK);
    axi_read(6'h04, 32'h0, OK, 0);
    axi_write(6'h00, 32'h2, 4'hF, 0, 0, OK);
    cycles(6);
    chk("manual_start_once", 32'(fs_cnt), 32'(fs0 + 1));
    axi_read(6'h00, 32'h0, OK, 0);
    chk("manual_commit_iter", 32'(max_iter), 32'h0400);

    for (int i = 0; i < 9; i++) begin
      axi_write(tbl[i].a, tbl[i].d, tbl[i].st, 0, 0, tbl[i].br);
      axi_read(tbl[i].a, tbl[i].rd, tbl[i].rr, 0);
    end
    axi_read(6'h08, 32'h1234_5678, OK, 0);
    chk("active_untouched", c_re_start, 32'hE000_0000);
    chk("no_start_in_table", 32'(fs_cnt), 32'(fs0 + 1));

    axi_read(6'h20, 32'h4D42_0001, OK, 4);
    axi_read(6'h14, 32'h0026_66DD, OK, 4);

    cycles(3);
    chk("bq_drained", 32'(bq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
